// File: rtl/npc_run_monitor.sv
// Run/halt monitor for the NPC core: exit classification, saturating counters, optional PC trace.
// Define NPC_PC_TRACE_EN to build the last-committed-PC ring buffer.
module npc_run_monitor #(
  parameter int unsigned XLEN        = 64,
  parameter int unsigned PC_W        = 32,
  parameter int unsigned CNT_W       = 64,
  parameter int unsigned WDOG_CYC    = 4096,
  parameter int unsigned DRAIN_CYC   = 2,
  parameter int unsigned TRACE_DEPTH = 16,
  localparam int unsigned IdxW       = $clog2(TRACE_DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             commit_valid,
  input  logic [PC_W-1:0]  commit_pc,
  input  logic             ebreak,
  input  logic [XLEN-1:0]  x10,
  output logic             halt,
  output logic [1:0]       halt_code,
  output logic [XLEN-1:0]  exit_value,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt,
  input  logic [IdxW-1:0]  trace_idx,
  output logic [PC_W-1:0]  trace_pc,
  output logic [IdxW:0]    trace_fill
);

  localparam int unsigned WdogW  = $clog2(WDOG_CYC);
  localparam int unsigned DrainW = $clog2(DRAIN_CYC) + 1;
  localparam logic [CNT_W-1:0] CntMax = '1;

  typedef enum logic [1:0] {StRun, StDrain, StHalt} state_e;

  state_e            state_q, state_d;
  logic [WdogW-1:0]  wdog_q, wdog_d;
  logic [DrainW-1:0] drain_q, drain_d;
  logic [1:0]        code_q, code_d;
  logic [XLEN-1:0]   exit_q, exit_d;
  logic [CNT_W-1:0]  cyc_q, cyc_d, inst_q, inst_d;
  logic              commit_run;

  always_comb begin
    state_d    = state_q;
    wdog_d     = wdog_q;
    drain_d    = drain_q;
    code_d     = code_q;
    exit_d     = exit_q;
    cyc_d      = cyc_q;
    inst_d     = inst_q;
    commit_run = 1'b0;
    unique case (state_q)
      StRun: begin
        if (cyc_q != CntMax) cyc_d = cyc_q + CNT_W'(1);
        // A commit clears the watchdog, so it beats a simultaneous expiry.
        if (commit_valid) begin
          commit_run = 1'b1;
          wdog_d     = '0;
          if (inst_q != CntMax) inst_d = inst_q + CNT_W'(1);
          if (ebreak) begin
            exit_d  = x10;
            drain_d = DrainW'(DRAIN_CYC - 1);
            state_d = StDrain;
          end
        end else if (wdog_q == WdogW'(WDOG_CYC - 1)) begin
          state_d = StHalt;
          code_d  = 2'd3;
        end else begin
          wdog_d = wdog_q + WdogW'(1);
        end
      end
      StDrain: begin
        if (cyc_q != CntMax) cyc_d = cyc_q + CNT_W'(1);
        if (drain_q == '0) begin
          state_d = StHalt;
          code_d  = (exit_q == '0) ? 2'd1 : 2'd2;
        end else begin
          drain_d = drain_q - DrainW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StRun;
      wdog_q  <= '0;
      drain_q <= '0;
      code_q  <= '0;
      exit_q  <= '0;
      cyc_q   <= '0;
      inst_q  <= '0;
    end else begin
      state_q <= state_d;
      wdog_q  <= wdog_d;
      drain_q <= drain_d;
      code_q  <= code_d;
      exit_q  <= exit_d;
      cyc_q   <= cyc_d;
      inst_q  <= inst_d;
    end
  end

  assign halt        = (state_q == StHalt);
  assign halt_code   = code_q;
  assign exit_value  = exit_q;
  assign cycle_cnt   = cyc_q;
  assign instret_cnt = inst_q;

`ifdef NPC_PC_TRACE_EN
  localparam int unsigned FillW = IdxW + 1;
  localparam logic [FillW-1:0] FillMax = FillW'(TRACE_DEPTH);

  logic [PC_W-1:0]  mem_q [TRACE_DEPTH];
  logic [IdxW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr;
  logic [FillW-1:0] fill_q, fill_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    fill_d   = fill_q;
    if (commit_run) begin
      wr_ptr_d = wr_ptr_q + IdxW'(1);
      if (fill_q != FillMax) fill_d = fill_q + FillW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      fill_q   <= '0;
      for (int i = 0; i < int'(TRACE_DEPTH); i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      fill_q   <= fill_d;
      if (commit_run) mem_q[wr_ptr_q] <= commit_pc;
    end
  end

  // Index 0 is the entry just behind the write pointer; depth is a power of 2 so wrap is free.
  assign rd_ptr     = wr_ptr_q - IdxW'(1) - trace_idx;
  assign trace_pc   = ({1'b0, trace_idx} < fill_q) ? mem_q[rd_ptr] : '0;
  assign trace_fill = fill_q;
`else
  logic unused_trace;
  assign unused_trace = ^{trace_idx, commit_pc, commit_run};
  assign trace_pc     = '0;
  assign trace_fill   = '0;
`endif

endmodule
